// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// quotient value reported on a divide by zero.
package div_iter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Widest operand supported; narrower instances slice the low bits.
    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: W-bit subtract a - b computed as a + ~b + 1.
// borrow=1 means the difference went negative.
module div_sub_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        diff   = sum[W-1:0];
        borrow = ~sum[W];
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned integer divider, one restoring step per clock.
// Start/busy/done handshake; results hold until the next accepted start.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_busy,
    output logic             div_done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Handshake: a request is taken on any rising edge where div_start=1 and
    // div_busy=0; operands are sampled only on that edge.
    state_t           state, state_nx;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;   // partial remainder
    logic [WIDTH-1:0] dq;      // dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0] dv;      // |divisor|
    logic             qsign;
    logic             rsign;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             op_neg_x;
    logic             op_neg_y;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    assign partial  = {rem_r, dq[WIDTH-1]};
    assign op_neg_x = div_signed & dividend[WIDTH-1];
    assign op_neg_y = div_signed & divisor[WIDTH-1];

    div_sub_step #(.W(WIDTH + 1)) u_step (
        .a      (partial),
        .b      ({1'b0, dv}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (div_start) begin
                    accept   = 1'b1;
                    state_nx = (divisor == '0) ? S_DONE : S_CALC;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CALC:  if (cnt == LAST) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt         <= '0;
            rem_r       <= '0;
            dq          <= '0;
            dv          <= '0;
            qsign       <= 1'b0;
            rsign       <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else if (accept) begin
            cnt         <= '0;
            rem_r       <= '0;
            dq          <= op_neg_x ? neg(dividend) : dividend;
            dv          <= op_neg_y ? neg(divisor) : divisor;
            qsign       <= op_neg_x ^ op_neg_y;
            rsign       <= op_neg_x;
            div_by_zero <= (divisor == '0);
            // A zero divisor skips the iterations and reports immediately.
            if (divisor == '0) begin
                quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
                remainder <= dividend;
            end
        end else if (state == S_CALC) begin
            cnt   <= cnt + CW'(1);
            rem_r <= borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
            dq    <= {dq[WIDTH-2:0], ~borrow};
        end else if (state == S_FIX) begin
            quotient  <= qsign ? neg(dq) : dq;
            remainder <= rsign ? neg(rem_r) : rem_r;
        end
    end

    assign div_busy  = (state == S_CALC) || (state == S_FIX);
    assign div_done  = (state == S_DONE);
    assign dbg_state = state;

endmodule
